// File: rtl/vga_capture.sv
// vga_capture: receive-side raster checker for the VGA display path.
// Samples HSync/VSync/RGB in the system clock domain. It recovers pixel
// coordinates, measures line length and frame height, and locks onto a stable
// raster after LOCK_FRAMES consecutive matching frames.
//
// Ports:
//   Clock, Reset_n        system clock, synchronous active-low reset
//   HSync, VSync          active-high sync pulses
//   R, G, B               4-bit colour inputs
//   PixValid              high for each visible pixel while Locked
//   PixX, PixY            coordinates of the current pixel
//   PixData               {R,G,B} of the current pixel
//   FrameStart            one-clock pulse on each VSync fall while Locked
//   LineLen, FrameLines   last measured line length / lines per frame
//   Locked, SyncErr       lock status, one-clock pulse on loss of lock
//   FrameCrc              CRC-16-CCITT of the visible frame (optional)
//
// Optional feature: define VGA_CAPTURE_CRC_EN to add the FrameCrc port and
// its CRC accumulator.

module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_BACK      = 32,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        HSync,
  input  logic        VSync,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic        PixValid,
  output logic [9:0]  PixX,
  output logic [9:0]  PixY,
  output logic [11:0] PixData,
  output logic        FrameStart,
  output logic [11:0] LineLen,
  output logic [9:0]  FrameLines,
  output logic        Locked,
  output logic        SyncErr
`ifdef VGA_CAPTURE_CRC_EN
  ,
  output logic [15:0] FrameCrc
`endif
);

  localparam logic [11:0] H_START    = 12'(H_BACK);
  localparam logic [11:0] H_END      = 12'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_START    = 10'(V_BACK);
  localparam logic [9:0]  V_END      = 10'(V_BACK + V_ACTIVE);
  localparam logic [11:0] TIMEOUT_C  = 12'(TIMEOUT);
  localparam logic [7:0]  MATCH_LAST = 8'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  state_t      state, state_next;
  logic        hsync_s1, hsync_s2, vsync_s1, vsync_s2;
  logic [11:0] rgb_s1;
  logic        h_fall, v_fall;
  logic [11:0] h_cnt, line_meas, ref_line, h_off;
  logic [9:0]  v_cnt, ref_lines, v_off;
  logic [7:0]  match_cnt;
  logic        line_seen;
  logic        line_bad, frame_bad, lock_err, in_window;
  logic        pix_valid_next, frame_start_next, sync_err_next;

  // Input stage: one register for everything, a second for the syncs so a
  // falling edge is seen as s2=1, s1=0.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      hsync_s1 <= 1'b0;
      hsync_s2 <= 1'b0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      rgb_s1   <= '0;
    end else begin
      hsync_s1 <= HSync;
      hsync_s2 <= hsync_s1;
      vsync_s1 <= VSync;
      vsync_s2 <= vsync_s1;
      rgb_s1   <= {R, G, B};
    end
  end

  always_comb begin
    h_fall    = hsync_s2 & ~hsync_s1;
    v_fall    = vsync_s2 & ~vsync_s1;
    line_meas = (h_cnt == 12'hFFF) ? 12'hFFF : h_cnt + 12'd1;
    // Line check comes first; a coincident frame check is OR-ed into the
    // same error so both mismatches yield a single SyncErr.
    line_bad  = h_fall && (line_meas != ref_line);
    frame_bad = v_fall && (v_cnt != ref_lines);
    lock_err  = line_bad || frame_bad || (h_cnt >= TIMEOUT_C);
    h_off     = h_cnt - H_START;
    v_off     = v_cnt - V_START;
    in_window = (h_cnt >= H_START) && (h_cnt < H_END) &&
                (v_cnt >= V_START) && (v_cnt < V_END);
  end

  // Raster counters and the measured geometry. VSync clear beats the
  // HSync increment, so FrameLines takes the pre-clear count.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      LineLen    <= '0;
      FrameLines <= '0;
    end else begin
      if (h_fall) begin
        h_cnt   <= '0;
        LineLen <= line_meas;
      end else if (h_cnt != 12'hFFF) begin
        h_cnt <= h_cnt + 12'd1;
      end
      if (v_fall) begin
        v_cnt      <= '0;
        FrameLines <= v_cnt;
      end else if (h_fall && (v_cnt != 10'h3FF)) begin
        v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= SEARCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (v_fall) state_next = MEASURE;
      MEASURE: if (v_fall) state_next = VERIFY;
      VERIFY: begin
        if (line_bad || frame_bad)                      state_next = SEARCH;
        else if (v_fall && (match_cnt == MATCH_LAST))  state_next = LOCKED;
      end
      LOCKED:  if (lock_err) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    Locked           = (state == LOCKED);
    pix_valid_next   = in_window && Locked;
    sync_err_next    = Locked && lock_err;
    frame_start_next = Locked && v_fall && !lock_err;
  end

  // Reference geometry captured while measuring, and the match counter.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ref_line  <= '0;
      ref_lines <= '0;
      match_cnt <= '0;
      line_seen <= 1'b0;
    end else begin
      case (state)
        SEARCH: line_seen <= 1'b0;
        MEASURE: begin
          if (h_fall && !line_seen) begin
            ref_line  <= line_meas;
            line_seen <= 1'b1;
          end
          if (v_fall) begin
            ref_lines <= v_cnt;
            match_cnt <= '0;
          end
        end
        VERIFY: begin
          if (v_fall && !line_bad && !frame_bad) match_cnt <= match_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered pixel outputs; coordinates and data hold between pixels.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      PixValid   <= 1'b0;
      PixX       <= '0;
      PixY       <= '0;
      PixData    <= '0;
      FrameStart <= 1'b0;
      SyncErr    <= 1'b0;
    end else begin
      PixValid   <= pix_valid_next;
      FrameStart <= frame_start_next;
      SyncErr    <= sync_err_next;
      if (pix_valid_next) begin
        PixX    <= h_off[9:0];
        PixY    <= v_off;
        PixData <= rgb_s1;
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_acc;

  function automatic logic [15:0] crc12(input logic [15:0] crc_in,
                                        input logic [11:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Accumulator idles at the init value whenever unlocked so the first
  // latched CRC after lock covers exactly one whole frame.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      crc_acc  <= 16'hFFFF;
      FrameCrc <= '0;
    end else begin
      if (v_fall && Locked) FrameCrc <= crc_acc;
      if (v_fall || !Locked) crc_acc <= 16'hFFFF;
      else if (PixValid)     crc_acc <= crc12(crc_acc, PixData);
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
module tb_vga_capture;

  localparam int HA   = 8;
  localparam int HB   = 3;
  localparam int VA   = 4;
  localparam int VB   = 2;
  localparam int LF   = 2;
  localparam int TO   = 100;
  localparam int LINE = 20;
  localparam int HS   = 3;
  localparam int NL   = 10;
  localparam int VS   = 2;
  localparam int PX0  = HS + 1 + HB;
  localparam int RY0  = VB + VS - 1;

  logic        clock = 1'b0;
  logic        reset_n, h_sync, v_sync;
  logic [3:0]  r, g, b;
  logic        pix_valid, frame_start, locked, sync_err;
  logic [9:0]  pix_x, pix_y, frame_lines;
  logic [11:0] pix_data, line_len;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
`endif

  int tests = 0;
  int failures = 0;
  int pix_total = 0;
  int pix_bad = 0;
  int err_total = 0;
  int fs_total = 0;
  logic [11:0] pix00 = '0;

  always #5 clock = ~clock;

  vga_capture #(
    .H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB),
    .LOCK_FRAMES(LF), .TIMEOUT(TO)
  ) dut (
    .Clock(clock), .Reset_n(reset_n), .HSync(h_sync), .VSync(v_sync),
    .R(r), .G(g), .B(b),
    .PixValid(pix_valid), .PixX(pix_x), .PixY(pix_y), .PixData(pix_data),
    .FrameStart(frame_start), .LineLen(line_len), .FrameLines(frame_lines),
    .Locked(locked), .SyncErr(sync_err)
`ifdef VGA_CAPTURE_CRC_EN
    , .FrameCrc(frame_crc)
`endif
  );

  // Event counters and an independent pixel-content check against the
  // source pattern {x, y, 5}.
  always @(negedge clock) begin
    if (pix_valid) begin
      pix_total++;
      if (pix_x >= 10'(HA) || pix_y >= 10'(VA) ||
          pix_data !== {pix_x[3:0], pix_y[3:0], 4'h5})
        pix_bad++;
      if (pix_x == 10'd0 && pix_y == 10'd0) pix00 = pix_data;
    end
    if (sync_err)    err_total++;
    if (frame_start) fs_total++;
  end

  task automatic applyStimulus(input logic hs, input logic vs, input logic [11:0] rgb);
    h_sync = hs;
    v_sync = vs;
    {r, g, b} = rgb;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives lines j0..j1 of the source raster; HSync high at line start,
  // VSync high for the first VS lines (extended to the HSync fall when coin).
  task automatic runLines(input int j0, input int j1, input int short_line, input bit coin);
    int len;
    logic hs, vs;
    logic [11:0] rgb;
    logic [3:0] xv, yv;
    for (int j = j0; j <= j1; j++) begin
      len = (j == short_line) ? LINE - 1 : LINE;
      for (int p = 0; p < len; p++) begin
        hs = (p < HS);
        vs = coin ? ((j < VS) || (j == VS && p < HS)) : (j < VS);
        if (p >= PX0 && p < PX0 + HA && j >= RY0 && j < RY0 + VA) begin
          xv  = 4'(p - PX0);
          yv  = 4'(j - RY0);
          rgb = {xv, yv, 4'h5};
        end else begin
          rgb = '0;
        end
        applyStimulus(hs, vs, rgb);
      end
    end
  endtask

  task automatic runFrame(input int short_line, input bit coin);
    runLines(0, NL - 1, short_line, coin);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " PixValid"},   32'(pix_valid),   32'd0);
    checkOutput({tag, " PixX"},       32'(pix_x),       32'd0);
    checkOutput({tag, " PixY"},       32'(pix_y),       32'd0);
    checkOutput({tag, " PixData"},    32'(pix_data),    32'd0);
    checkOutput({tag, " FrameStart"}, 32'(frame_start), 32'd0);
    checkOutput({tag, " LineLen"},    32'(line_len),    32'd0);
    checkOutput({tag, " FrameLines"}, 32'(frame_lines), 32'd0);
    checkOutput({tag, " Locked"},     32'(locked),      32'd0);
    checkOutput({tag, " SyncErr"},    32'(sync_err),    32'd0);
  endtask

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] expectedCrc();
    logic [15:0] c;
    logic [11:0] d;
    logic [3:0] xv, yv;
    c = 16'hFFFF;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        xv = 4'(x);
        yv = 4'(y);
        d = {xv, yv, 4'h5};
        for (int i = 11; i >= 0; i--) begin
          if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
          else              c = {c[14:0], 1'b0};
        end
      end
    end
    return c;
  endfunction
`endif

  initial begin
    int e0, f0, p0;

    // Reset state
    reset_n = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 12'h000);
    checkAllZero("reset");
    reset_n = 1'b1;

    // Nominal lock: F0 measure start, F1 reference, F2/F3 verify -> lock
    e0 = err_total; f0 = fs_total; p0 = pix_total;
    repeat (4) runFrame(-1, 1'b0);
    checkOutput("lock Locked",     32'(locked),      32'd1);
    checkOutput("lock LineLen",    32'(line_len),    32'd20);
    checkOutput("lock FrameLines", 32'(frame_lines), 32'd10);
    checkOutput("lock no SyncErr", 32'(err_total - e0), 32'd0);
    checkOutput("lock no FrameStart before lock", 32'(fs_total - f0), 32'd0);
    checkOutput("lock pixels in lock frame", 32'(pix_total - p0), 32'd32);

    // Pixel mapping over one full locked frame
    f0 = fs_total; p0 = pix_total;
    runFrame(-1, 1'b0);
    checkOutput("map FrameStart",  32'(fs_total - f0),  32'd1);
    checkOutput("map pixel count", 32'(pix_total - p0), 32'd32);
    checkOutput("map pixel content", 32'(pix_bad),      32'd0);
    checkOutput("map first pixel", 32'(pix00),          32'h005);
    checkOutput("map hold PixX",   32'(pix_x),          32'd7);
    checkOutput("map hold PixY",   32'(pix_y),          32'd3);
    checkOutput("map hold PixData", 32'(pix_data),      32'h735);
    checkOutput("map PixValid idle", 32'(pix_valid),    32'd0);
    checkOutput("map no SyncErr",  32'(err_total - e0), 32'd0);
`ifdef VGA_CAPTURE_CRC_EN
    checkOutput("crc frame", 32'(frame_crc), 32'(expectedCrc()));
`endif

    // Line glitch: line 5 shortened to 19 clocks
    e0 = err_total; f0 = fs_total;
    runFrame(5, 1'b0);
    checkOutput("glitch SyncErr pulse", 32'(err_total - e0), 32'd1);
    checkOutput("glitch Locked",        32'(locked),         32'd0);
    checkOutput("glitch FrameStart",    32'(fs_total - f0),  32'd1);
    repeat (3) runFrame(-1, 1'b0);
    checkOutput("relock pending", 32'(locked), 32'd0);
    runFrame(-1, 1'b0);
    checkOutput("relock Locked", 32'(locked), 32'd1);
    checkOutput("relock single SyncErr", 32'(err_total - e0), 32'd1);

    // Mid-frame reset while locked
    e0 = err_total;
    runLines(0, 4, -1, 1'b0);
    reset_n = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0, 12'h000);
    checkAllZero("midreset");
    reset_n = 1'b1;
    repeat (4) runFrame(-1, 1'b0);
    checkOutput("midreset no SyncErr", 32'(err_total - e0), 32'd0);
    checkOutput("midreset relock",     32'(locked),         32'd1);

    // Timeout: h_cnt is 15 at frame end, reaches TO=100 after 85 idle clocks
    for (int i = 0; i < 85; i++) applyStimulus(1'b0, 1'b0, 12'h000);
    checkOutput("timeout before SyncErr", 32'(sync_err), 32'd0);
    checkOutput("timeout before Locked",  32'(locked),   32'd1);
    applyStimulus(1'b0, 1'b0, 12'h000);
    checkOutput("timeout SyncErr", 32'(sync_err), 32'd1);
    checkOutput("timeout Locked",  32'(locked),   32'd0);
    applyStimulus(1'b0, 1'b0, 12'h000);
    checkOutput("timeout pulse width", 32'(sync_err), 32'd0);

    // Coincident HSync/VSync falls: the coincident line is not counted
    reset_n = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 12'h000);
    reset_n = 1'b1;
    e0 = err_total;
    repeat (4) runFrame(-1, 1'b1);
    checkOutput("coin Locked",     32'(locked),      32'd1);
    checkOutput("coin FrameLines", 32'(frame_lines), 32'd9);
    checkOutput("coin LineLen",    32'(line_len),    32'd20);
    f0 = fs_total;
    runFrame(-1, 1'b1);
    checkOutput("coin FrameStart", 32'(fs_total - f0),  32'd1);
    checkOutput("coin no SyncErr", 32'(err_total - e0), 32'd0);
    checkOutput("coin stays Locked", 32'(locked),       32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
